// File: rtl/cla_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead adder.
//   GROUP_WIDTH          : width of one lookahead group
//   cla_slice_width()    : bits handled by each pipeline slice
//   cla_groups_per_slice : lookahead groups inside one slice
//   cla_cfg_ok()         : legality of an (ADDER_WIDTH, STAGES) pair
//   cla_stage_ctrl_t     : control half of a stage payload (valid + carry)
package cla_pkg;

  localparam int GROUP_WIDTH = 4;

  function automatic int cla_slice_width(input int adder_width, input int stages);
    return adder_width / stages;
  endfunction

  function automatic int cla_groups_per_slice(input int adder_width, input int stages);
    return adder_width / (stages * GROUP_WIDTH);
  endfunction

  function automatic bit cla_cfg_ok(input int adder_width, input int stages);
    return (stages > 0) && (adder_width > 0) &&
           ((adder_width % (GROUP_WIDTH * stages)) == 0);
  endfunction

  // The data half of the payload depends on ADDER_WIDTH, so it is wrapped
  // around this struct inside the adder module.
  typedef struct packed {
    logic valid;  // stage holds a live transaction
    logic carry;  // carry out of the slice finished in this stage
  } cla_stage_ctrl_t;

endpackage

// File: rtl/cla_group_4b.sv
// Purely combinational 4-bit carry-lookahead group.
//   i_a, i_b : 4-bit operands
//   i_cin    : carry into bit 0
//   o_sum    : 4-bit sum
//   o_g/o_p  : group generate / propagate (independent of i_cin)
//   o_c_msb  : carry into bit 3
//   o_cout   : carry out of bit 3
module cla_group_4b (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_g,
  output logic       o_p,
  output logic       o_c_msb,
  output logic       o_cout
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic       w_c1;
  logic       w_c2;
  logic       w_c3;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // Every internal carry is a flat sum of products, no ripple.
  assign w_c1 = w_g[0] | (w_p[0] & i_cin);
  assign w_c2 = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
  assign w_c3 = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0]) |
                (w_p[2] & w_p[1] & w_p[0] & i_cin);

  assign o_g = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1]) |
               (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
  assign o_p = &w_p;

  assign o_sum   = w_p ^ {w_c3, w_c2, w_c1, i_cin};
  assign o_c_msb = w_c3;
  assign o_cout  = o_g | (o_p & i_cin);

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready on both sides.
//   iClk, iRstN            : clock (rising edge), async active-low reset
//   iValid/oReady          : input handshake, transfer when both are high
//   iA, iB, iCarryIn, iSub : operands; iSub=1 computes A - B
//   oValid/iReady          : output handshake, transfer when both are high
//   oSum, oCarry           : result and carry out of the MSB
//   oOverflow, oZero       : signed overflow and all-zero result flags
// Handshake: a producer holding valid keeps its data stable until ready is
// seen high in the same cycle; ready may depend combinationally on the
// downstream ready. Latency is STAGES cycles when the output is not stalled.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int ADDER_WIDTH = 32,
  parameter int STAGES      = 4
) (
  input  logic                   iClk,
  input  logic                   iRstN,
  input  logic                   iValid,
  output logic                   oReady,
  input  logic [ADDER_WIDTH-1:0] iA,
  input  logic [ADDER_WIDTH-1:0] iB,
  input  logic                   iCarryIn,
  input  logic                   iSub,
  output logic                   oValid,
  input  logic                   iReady,
  output logic [ADDER_WIDTH-1:0] oSum,
  output logic                   oCarry,
  output logic                   oOverflow,
  output logic                   oZero
);

  localparam int  SW     = cla_slice_width(ADDER_WIDTH, STAGES);
  localparam int  NG     = cla_groups_per_slice(ADDER_WIDTH, STAGES);
  localparam bit  CFG_OK = cla_cfg_ok(ADDER_WIDTH, STAGES);
  localparam int  LAST   = STAGES - 1;

  if (!CFG_OK) begin : g_bad_cfg
    $error("ADDER_WIDTH must be a multiple of GROUP_WIDTH*STAGES");
  end

  // Finished low sum bits travel with the full operands; each stage only
  // overwrites its own slice of sum.
  typedef struct packed {
    cla_stage_ctrl_t        ctrl;
    logic [ADDER_WIDTH-1:0] sum;
    logic [ADDER_WIDTH-1:0] a;
    logic [ADDER_WIDTH-1:0] b;
  } stage_t;

  stage_t            r_stage [STAGES];
  logic [STAGES-1:0] w_load;
  logic              r_overflow;
  logic              r_zero;

  // A stage loads when empty or when its successor loads, so bubbles are
  // squeezed out even while the head is stalled.
  for (genvar k = 0; k < STAGES; k++) begin : g_load
    if (k == LAST) begin : g_tail
      assign w_load[k] = ~r_stage[k].ctrl.valid | iReady;
    end else begin : g_body
      assign w_load[k] = ~r_stage[k].ctrl.valid | w_load[k+1];
    end
  end

  assign oReady = w_load[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t          w_src;
    stage_t          w_next;
    logic [NG:0]     w_gc;
    logic [NG-1:0]   w_gg;
    logic [NG-1:0]   w_gp;
    logic [NG-1:0]   w_gc3;
    logic [NG-1:0]   w_gcout;
    logic [SW-1:0]   w_slice_sum;
    logic            w_unused_grp;

    if (k == 0) begin : g_src_in
      // Subtraction is A + ~B + 1, so the carry-in is forced high.
      always_comb begin
        w_src            = '0;
        w_src.ctrl.valid = iValid;
        w_src.ctrl.carry = iSub | iCarryIn;
        w_src.a          = iA;
        w_src.b          = iSub ? ~iB : iB;
      end
    end else begin : g_src_reg
      assign w_src = r_stage[k-1];
    end

    for (genvar g = 0; g < NG; g++) begin : g_grp
      cla_group_4b u_grp (
        .i_a     (w_src.a[k*SW + g*GROUP_WIDTH +: GROUP_WIDTH]),
        .i_b     (w_src.b[k*SW + g*GROUP_WIDTH +: GROUP_WIDTH]),
        .i_cin   (w_gc[g]),
        .o_sum   (w_slice_sum[g*GROUP_WIDTH +: GROUP_WIDTH]),
        .o_g     (w_gg[g]),
        .o_p     (w_gp[g]),
        .o_c_msb (w_gc3[g]),
        .o_cout  (w_gcout[g])
      );
    end

    // Group carries expanded from group P/G as flat products:
    // c[j] = cin&P[0..j-1] | OR_m G[m]&P[m+1..j-1]
    always_comb begin
      logic v_term;
      v_term  = 1'b0;
      w_gc    = '0;
      w_gc[0] = w_src.ctrl.carry;
      for (int j = 1; j <= NG; j++) begin
        v_term = w_src.ctrl.carry;
        for (int n = 0; n < j; n++) v_term = v_term & w_gp[n];
        w_gc[j] = v_term;
        for (int m = 0; m < j; m++) begin
          v_term = w_gg[m];
          for (int n = m + 1; n < j; n++) v_term = v_term & w_gp[n];
          w_gc[j] = w_gc[j] | v_term;
        end
      end
    end

    // Per-group carry outputs duplicate the lookahead carries.
    assign w_unused_grp = ^{w_gcout, w_gc3};

    always_comb begin
      w_next                      = w_src;
      w_next.sum[k*SW +: SW]      = w_slice_sum;
      w_next.ctrl.carry           = w_gc[NG];
    end

    always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
        r_stage[k] <= '0;
      end else if (w_load[k]) begin
        r_stage[k] <= w_next;
      end
    end

    if (k == LAST) begin : g_flags
      always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
          r_overflow <= 1'b0;
          r_zero     <= 1'b0;
        end else if (w_load[k]) begin
          r_overflow <= w_gc3[NG-1] ^ w_gc[NG];
          r_zero     <= ~|w_next.sum;
        end
      end
    end
  end

  logic w_unused_ops;
  assign w_unused_ops = ^{r_stage[LAST].a, r_stage[LAST].b};

  assign oValid    = r_stage[LAST].ctrl.valid;
  assign oSum      = r_stage[LAST].sum;
  assign oCarry    = r_stage[LAST].ctrl.carry;
  assign oOverflow = r_overflow;
  assign oZero     = r_zero;

endmodule
